// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the Processor core: owns the PC, reads the synchronous
// program RAM, issues each instruction with a Start strobe and prefetches mvi immediates.
module instr_fetch #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 7
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic              LoadPC,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic [DATA_W-1:0] MemOut,
    input  logic              Done,
    output logic [ADDR_W-1:0] AdressOut,
    output logic [DATA_W-1:0] DIN,
    output logic              Start,
    output logic              Busy,
    output logic              Fault,
    output logic [ADDR_W-1:0] PC
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_I,
        S_LATCH_I,
        S_LATCH_M,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] instr_reg;
    logic [DATA_W-1:0] imm_reg;
    logic              is_mvi;
    logic [CNT_W-1:0]  timeout_cnt;

    logic              load_pc;
    logic              latch_instr;
    logic              latch_imm;
    logic              clear_cnt;
    logic              inc_cnt;
    logic              advance_pc;
    logic              set_fault;

    logic [ADDR_W-1:0] pc_plus1;
    logic              mem_is_mvi;

    assign pc_plus1   = PC + ADDR_W'(1);
    assign mem_is_mvi = (MemOut[8:6] == 3'b001);

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // LATCH_I drives PC+1 so a possible mvi immediate arrives one cycle behind the opcode
    always_comb begin
        state_next  = state;
        load_pc     = 1'b0;
        latch_instr = 1'b0;
        latch_imm   = 1'b0;
        clear_cnt   = 1'b0;
        inc_cnt     = 1'b0;
        advance_pc  = 1'b0;
        set_fault   = 1'b0;
        Start       = 1'b0;
        Busy        = 1'b1;
        AdressOut   = PC;
        DIN         = instr_reg;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (LoadPC) begin
                    load_pc = 1'b1;
                end else if (Run) begin
                    state_next = S_FETCH_I;
                end
            end
            S_FETCH_I: begin
                state_next = S_LATCH_I;
            end
            S_LATCH_I: begin
                AdressOut   = pc_plus1;
                latch_instr = 1'b1;
                state_next  = mem_is_mvi ? S_LATCH_M : S_ISSUE;
            end
            S_LATCH_M: begin
                latch_imm  = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                Start      = 1'b1;
                clear_cnt  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                DIN = is_mvi ? imm_reg : instr_reg;
                if (Done) begin
                    advance_pc = 1'b1;
                    state_next = Run ? S_FETCH_I : S_IDLE;
                end else if (timeout_cnt == TIMEOUT_CNT) begin
                    set_fault  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            S_HALT: begin
                Busy = 1'b0;
            end
            default: begin
                Busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            PC          <= '0;
            instr_reg   <= '0;
            imm_reg     <= '0;
            is_mvi      <= 1'b0;
            timeout_cnt <= '0;
            Fault       <= 1'b0;
        end else begin
            if (load_pc) begin
                PC <= PCIn;
            end else if (advance_pc) begin
                PC <= PC + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
            end
            if (latch_instr) begin
                instr_reg <= MemOut;
                is_mvi    <= mem_is_mvi;
            end
            if (latch_imm) begin
                imm_reg <= MemOut;
            end
            if (clear_cnt) begin
                timeout_cnt <= '0;
            end else if (inc_cnt) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
            if (set_fault) begin
                Fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a RAM model and a core model surround the DUT,
// stimulus queues expected issue words and a monitor checks them as Start pulses appear.
module tb_instr_fetch;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic        LoadPC;
    logic [4:0]  PCIn;
    logic [15:0] MemOut;
    logic        Done;
    logic [4:0]  AdressOut;
    logic [15:0] DIN;
    logic        Start;
    logic        Busy;
    logic        Fault;
    logic [4:0]  PC;

    logic        core_done;
    logic        tb_done;
    logic [15:0] ram [0:31];

    typedef struct {
        logic [15:0] instr;
        bit          has_imm;
        logic [15:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    int          delay_q[$];
    int          vectors;
    int          miscompares;
    bit          imm_pending;
    logic [15:0] pend_imm;
    int          lat;

    assign Done = core_done | tb_done;

    instr_fetch #(.ADDR_W(5), .DATA_W(16), .TIMEOUT(7)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Run       (Run),
        .LoadPC    (LoadPC),
        .PCIn      (PCIn),
        .MemOut    (MemOut),
        .Done      (Done),
        .AdressOut (AdressOut),
        .DIN       (DIN),
        .Start     (Start),
        .Busy      (Busy),
        .Fault     (Fault),
        .PC        (PC)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) begin
        MemOut <= ram[AdressOut];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic run, input logic load_pc, input logic [4:0] pc_in);
        Run    = run;
        LoadPC = load_pc;
        PCIn   = pc_in;
    endtask

    task automatic push_expect(input logic [15:0] instr, input bit has_imm, input logic [15:0] imm,
                               input int done_delay);
        exp_t e;
        e.instr   = instr;
        e.has_imm = has_imm;
        e.imm     = imm;
        exp_q.push_back(e);
        delay_q.push_back(done_delay);
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        do begin
            @(negedge Clock);
            cycles++;
        end while (!Start && cycles < 50);
        check_output("start_seen", 32'(Start), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (Busy && n < 50);
        check_output("return_idle", 32'(Busy), 32'd0);
    endtask

    task automatic load_pc_value(input logic [4:0] value);
        apply_stimulus(1'b0, 1'b1, value);
        @(negedge Clock);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_output("pc_load", 32'(PC), 32'(value));
    endtask

    // Core model: a delay of 0 means the core never reports Done
    initial begin
        int d;
        core_done = 1'b0;
        forever begin
            @(negedge Clock);
            if (Start) begin
                d = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(posedge Clock);
                    #1 core_done = 1'b1;
                    @(posedge Clock);
                    #1 core_done = 1'b0;
                end
            end
        end
    end

    // Monitor: DIN at Start must be the opcode; for mvi the next cycle must carry the immediate
    always @(negedge Clock) begin
        if (imm_pending) begin
            check_output("wait_imm", 32'(DIN), 32'(pend_imm));
            imm_pending = 1'b0;
        end
        if (Start) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_start: got DIN %0h, expected no Start", DIN);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("issue_din", 32'(DIN), 32'(e.instr));
                if (e.has_imm) begin
                    imm_pending = 1'b1;
                    pend_imm    = e.imm;
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        imm_pending = 1'b0;
        pend_imm    = '0;
        tb_done     = 1'b0;
        Resetn      = 1'b1;
        apply_stimulus(1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
        ram[0] = 16'h0008;
        ram[1] = 16'h0090;
        ram[3] = 16'h0040;
        ram[4] = 16'h1234;
        ram[5] = 16'h0008;

        repeat (2) @(negedge Clock);
        check_output("rst_busy", 32'(Busy), 32'd0);
        check_output("rst_start", 32'(Start), 32'd0);
        check_output("rst_fault", 32'(Fault), 32'd0);
        check_output("rst_pc", 32'(PC), 32'd0);
        check_output("rst_addr", 32'(AdressOut), 32'd0);
        check_output("rst_din", 32'(DIN), 32'd0);
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check_output("idle_busy", 32'(Busy), 32'd0);
        check_output("idle_addr", 32'(AdressOut), 32'd0);

        // mv then add, Run dropped while the add is waiting for Done
        push_expect(16'h0008, 1'b0, 16'h0000, 1);
        push_expect(16'h0090, 1'b0, 16'h0000, 3);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        check_output("lat_nonmvi", 32'(lat), 32'd3);
        wait_start(lat);
        check_output("done_to_start", 32'(lat), 32'd4);
        @(negedge Clock);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        wait_idle();
        check_output("seq_pc", 32'(PC), 32'd2);
        repeat (6) @(negedge Clock);
        check_output("run_drop_idle", 32'(Busy), 32'd0);

        // mvi at address 3 with immediate at 4, Done in the first WAIT cycle
        load_pc_value(5'd3);
        check_output("load_idle", 32'(Busy), 32'd0);
        push_expect(16'h0040, 1'b1, 16'h1234, 1);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        check_output("lat_mvi", 32'(lat), 32'd4);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        wait_idle();
        check_output("mvi_pc", 32'(PC), 32'd5);

        // LoadPC wins over Run in IDLE
        apply_stimulus(1'b1, 1'b1, 5'd31);
        @(negedge Clock);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_output("loadpc_prio_pc", 32'(PC), 32'd31);
        check_output("loadpc_prio_busy", 32'(Busy), 32'd0);

        // mvi at the last address takes its immediate from address 0
        ram[31] = 16'h0040;
        ram[0]  = 16'hBEEF;
        push_expect(16'h0040, 1'b1, 16'hBEEF, 2);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        wait_idle();
        check_output("wrap_mvi_pc", 32'(PC), 32'd1);

        ram[31] = 16'h0090;
        load_pc_value(5'd31);
        push_expect(16'h0090, 1'b0, 16'h0000, 1);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        apply_stimulus(1'b0, 1'b0, 5'd0);
        wait_idle();
        check_output("wrap_pc", 32'(PC), 32'd0);

        // asynchronous reset in the middle of WAIT
        load_pc_value(5'd3);
        push_expect(16'h0040, 1'b1, 16'h1234, 0);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        repeat (2) @(negedge Clock);
        check_output("midwait_busy", 32'(Busy), 32'd1);
        #2 Resetn = 1'b1;
        apply_stimulus(1'b0, 1'b0, 5'd0);
        #1;
        check_output("async_busy", 32'(Busy), 32'd0);
        check_output("async_pc", 32'(PC), 32'd0);
        check_output("async_din", 32'(DIN), 32'd0);
        check_output("async_addr", 32'(AdressOut), 32'd0);
        @(negedge Clock);
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check_output("post_rst_busy", 32'(Busy), 32'd0);
        check_output("post_rst_addr", 32'(AdressOut), 32'd0);

        // timeout: the core never answers
        load_pc_value(5'd5);
        push_expect(16'h0008, 1'b0, 16'h0000, 0);
        apply_stimulus(1'b1, 1'b0, 5'd0);
        wait_start(lat);
        repeat (8) @(negedge Clock);
        check_output("pre_timeout_fault", 32'(Fault), 32'd0);
        check_output("pre_timeout_busy", 32'(Busy), 32'd1);
        @(negedge Clock);
        check_output("timeout_fault", 32'(Fault), 32'd1);
        check_output("halt_busy", 32'(Busy), 32'd0);
        apply_stimulus(1'b1, 1'b1, 5'd9);
        tb_done = 1'b1;
        repeat (4) @(negedge Clock);
        tb_done = 1'b0;
        apply_stimulus(1'b0, 1'b0, 5'd0);
        check_output("halt_fault", 32'(Fault), 32'd1);
        check_output("halt_busy2", 32'(Busy), 32'd0);
        check_output("halt_pc", 32'(PC), 32'd5);
        #2 Resetn = 1'b1;
        #1;
        check_output("rst_clears_fault", 32'(Fault), 32'd0);
        @(negedge Clock);
        Resetn = 1'b0;

        repeat (2) @(negedge Clock);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
